// File: rtl/msi_tlp_gen_if.sv
// TRN TX channel plus arbiter handshake shared between an MSI source and the
// TX arbiter/core.
interface msi_tlp_gen_if;
  logic        tx_req;
  logic        tx_grant;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n;
  logic        trn_teof_n;
  logic        trn_tsrc_rdy_n;
  logic        trn_tdst_rdy_n;

  modport master (
    output tx_req, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
    input  tx_grant, trn_tdst_rdy_n
  );

  modport slave (
    input  tx_req, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
    output tx_grant, trn_tdst_rdy_n
  );
endinterface

// File: rtl/msi_tlp_gen.sv
// MSI memory-write TLP generator on a 64-bit TRN TX channel (3DW or 4DW header).
// Optional macro MSI_HOLDOFF_EN: enforce HOLDOFF_CYCLES idle cycles between TLPs.
module msi_tlp_gen #(
  parameter int unsigned HOLDOFF_CYCLES = 256
) (
  input  logic          trn_clk,
  input  logic          reset_n,
  input  logic          cfg_interrupt_msienable,
  input  logic [63:0]   msi_message_addr,
  input  logic [15:0]   msi_message_data,
  input  logic [15:0]   cfg_completer_id,
  input  logic          irq_req,
  msi_tlp_gen_if.master tx,
  output logic          tx_done,
  output logic [31:0]   irq_count
);

  localparam int unsigned AW = 62;

  typedef enum logic [2:0] {IDLE, ARB, BEAT0, BEAT1, BEAT2, HOLD} state_e;

  state_e         state_q, state_d;
  logic           pending_q, pending_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [15:0]    data_q, data_d;
  logic [15:0]    cid_q, cid_d;
  logic [31:0]    count_q, count_d;
  logic           done_q, done_d;
  logic           req_q, req_d;
  logic [63:0]    td_q, td_d;
  logic [7:0]     rem_q, rem_d;
  logic           sof_q, sof_d;
  logic           eof_q, eof_d;
  logic           src_q, src_d;

  logic           accept;
  logic           finish;
  logic           is64;
  logic [2:0]     fmt;
  logic [31:0]    dw0, dw1, payload;

  // Dword alignment drops the two address LSBs.
  logic           unused_addr_lsb;
  assign unused_addr_lsb = ^msi_message_addr[1:0];

  // HOLDOFF_CYCLES must be at least one.
  if (HOLDOFF_CYCLES == 0) begin : g_holdoff_zero_invalid
  end

`ifdef MSI_HOLDOFF_EN
  localparam int unsigned HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

  assign accept = ~tx.trn_tdst_rdy_n;

  // Next-state, pending/latch control and registered output decode.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | (irq_req & cfg_interrupt_msienable);
    addr_d    = addr_q;
    data_d    = data_q;
    cid_d     = cid_q;
    count_d   = count_q;
    done_d    = 1'b0;
    finish    = 1'b0;
`ifdef MSI_HOLDOFF_EN
    hold_cnt_d = hold_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (pending_d && cfg_interrupt_msienable) state_d = ARB;
      end
      ARB: begin
        if (!cfg_interrupt_msienable) begin
          state_d = IDLE;
        end else if (tx.tx_grant) begin
          state_d   = BEAT0;
          addr_d    = msi_message_addr[63:2];
          data_d    = msi_message_data;
          cid_d     = cfg_completer_id;
          // A request coinciding with the grant belongs to the next TLP.
          pending_d = irq_req;
        end
      end
      BEAT0: begin
        if (accept) state_d = BEAT1;
      end
      BEAT1: begin
        if (accept) begin
          if (addr_q[AW-1:30] != 32'h0) state_d = BEAT2;
          else                          finish  = 1'b1;
        end
      end
      BEAT2: begin
        if (accept) finish = 1'b1;
      end
      HOLD: begin
`ifdef MSI_HOLDOFF_EN
        if (hold_cnt_q == '0) state_d = IDLE;
        else                  hold_cnt_d = hold_cnt_q - HOLD_W'(1);
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d = HOLD;
      done_d  = 1'b1;
      count_d = count_q + 32'd1;
`ifdef MSI_HOLDOFF_EN
      hold_cnt_d = HOLD_W'(HOLDOFF_CYCLES - 1);
`endif
    end

    if (!cfg_interrupt_msienable) pending_d = 1'b0;

    // Beat contents follow the next state so the bus holds while stalled.
    is64    = (addr_d[AW-1:30] != 32'h0);
    fmt     = is64 ? 3'b011 : 3'b010;
    dw0     = {fmt, 5'd0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 2'd0, 2'd0, 10'd1};
    dw1     = {cid_d, 8'h00, 4'h0, 4'hF};
    payload = {data_d[7:0], data_d[15:8], 16'h0000};

    td_d  = 64'h0;
    rem_d = 8'h00;
    sof_d = 1'b1;
    eof_d = 1'b1;
    src_d = 1'b1;
    req_d = 1'b0;

    unique case (state_d)
      ARB: req_d = 1'b1;
      BEAT0: begin
        req_d = 1'b1;
        src_d = 1'b0;
        sof_d = 1'b0;
        td_d  = {dw0, dw1};
      end
      BEAT1: begin
        req_d = 1'b1;
        src_d = 1'b0;
        if (is64) begin
          td_d = {addr_d[AW-1:30], addr_d[29:0], 2'b00};
        end else begin
          td_d  = {addr_d[29:0], 2'b00, payload};
          eof_d = 1'b0;
        end
      end
      BEAT2: begin
        req_d = 1'b1;
        src_d = 1'b0;
        eof_d = 1'b0;
        rem_d = 8'h0F;
        td_d  = {payload, 32'h0};
      end
      default: ;
    endcase
  end

  // State and output registers; reset aborts any TLP in flight.
  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      cid_q     <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      req_q     <= 1'b0;
      td_q      <= '0;
      rem_q     <= 8'h00;
      sof_q     <= 1'b1;
      eof_q     <= 1'b1;
      src_q     <= 1'b1;
`ifdef MSI_HOLDOFF_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cid_q     <= cid_d;
      count_q   <= count_d;
      done_q    <= done_d;
      req_q     <= req_d;
      td_q      <= td_d;
      rem_q     <= rem_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
      src_q     <= src_d;
`ifdef MSI_HOLDOFF_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign tx.tx_req         = req_q;
  assign tx.trn_td         = td_q;
  assign tx.trn_trem_n     = rem_q;
  assign tx.trn_tsof_n     = sof_q;
  assign tx.trn_teof_n     = eof_q;
  assign tx.trn_tsrc_rdy_n = src_q;
  assign tx_done           = done_q;
  assign irq_count         = count_q;

endmodule

// File: tb/tb_msi_tlp_gen.sv
// Scoreboard bench for msi_tlp_gen: expected beats queued at stimulus time,
// popped by a bus monitor on every accepted beat.
`timescale 1ns/1ps
module tb_msi_tlp_gen;

`ifdef MSI_HOLDOFF_EN
  localparam int unsigned HOLD_LEN = 256;
`else
  localparam int unsigned HOLD_LEN = 1;
`endif
  localparam logic [15:0] CID = 16'h01A5;

  typedef struct {
    logic [63:0] td;
    logic        sof;
    logic        eof;
    logic [7:0]  rem;
  } beat_t;

  logic        trn_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        msien   = 1'b0;
  logic        irq     = 1'b0;
  logic [63:0] addr    = 64'h0;
  logic [15:0] data    = 16'h0;
  logic        tx_done;
  logic [31:0] irq_count;

  int          checks    = 0;
  int          errors    = 0;
  int          cyc       = 0;
  int          exp_count = 0;
  beat_t       exp_q[$];

  msi_tlp_gen_if tx_if();

  msi_tlp_gen dut (
    .trn_clk                 (trn_clk),
    .reset_n                 (reset_n),
    .cfg_interrupt_msienable (msien),
    .msi_message_addr        (addr),
    .msi_message_data        (data),
    .cfg_completer_id        (CID),
    .irq_req                 (irq),
    .tx                      (tx_if),
    .tx_done                 (tx_done),
    .irq_count               (irq_count)
  );

  always #5 trn_clk = ~trn_clk;

  always @(posedge trn_clk) cyc <= cyc + 1;

  // Monitor: every beat accepted by the sink must match the queue head.
  always @(negedge trn_clk) begin : monitor
    beat_t e;
    if (reset_n && !tx_if.trn_tsrc_rdy_n && !tx_if.trn_tdst_rdy_n) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat got td=%h sof=%b eof=%b rem=%h", tx_if.trn_td,
                 tx_if.trn_tsof_n, tx_if.trn_teof_n, tx_if.trn_trem_n);
      end else begin
        e = exp_q.pop_front();
        if ({tx_if.trn_td, tx_if.trn_tsof_n, tx_if.trn_teof_n, tx_if.trn_trem_n} !==
            {e.td, e.sof, e.eof, e.rem}) begin
          errors++;
          $display("FAIL beat got td=%h sof=%b eof=%b rem=%h want td=%h sof=%b eof=%b rem=%h",
                   tx_if.trn_td, tx_if.trn_tsof_n, tx_if.trn_teof_n, tx_if.trn_trem_n,
                   e.td, e.sof, e.eof, e.rem);
        end
      end
    end
  end

  task automatic push_tlp(input logic [63:0] a, input logic [15:0] d);
    beat_t       b;
    logic [31:0] pay;
    logic [31:0] hi;
    pay = {d[7:0], d[15:8], 16'h0000};
    hi  = a[63:32];
    b.td = {(hi == 32'h0) ? 32'h4000_0001 : 32'h6000_0001, CID, 16'h000F};
    b.sof = 1'b0; b.eof = 1'b1; b.rem = 8'h00;
    exp_q.push_back(b);
    b.sof = 1'b1;
    if (hi == 32'h0) begin
      b.td = {a[31:2], 2'b00, pay}; b.eof = 1'b0; b.rem = 8'h00;
      exp_q.push_back(b);
    end else begin
      b.td = {hi, a[31:2], 2'b00}; b.eof = 1'b1; b.rem = 8'h00;
      exp_q.push_back(b);
      b.td = {pay, 32'h0}; b.eof = 1'b0; b.rem = 8'h0F;
      exp_q.push_back(b);
    end
    exp_count++;
  endtask

  task automatic pulse_irq();
    @(posedge trn_clk); #1 irq = 1'b1;
    @(posedge trn_clk); #1 irq = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge trn_clk);
      if (tx_done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_sof(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge trn_clk);
      if (tx_if.trn_tsrc_rdy_n === 1'b0 && tx_if.trn_tsof_n === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic idle_wait();
    repeat (HOLD_LEN + 4) @(negedge trn_clk);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({tx_if.tx_req, tx_done, irq_count} !== 34'h0) begin
      errors++;
      $display("FAIL reset_ctrl got req=%b done=%b count=%0d want 0 0 0", tx_if.tx_req, tx_done, irq_count);
    end
    checks++;
    if ({tx_if.trn_td, tx_if.trn_trem_n} !== 72'h0) begin
      errors++;
      $display("FAIL reset_data got td=%h rem=%h want 0 00", tx_if.trn_td, tx_if.trn_trem_n);
    end
    checks++;
    if ({tx_if.trn_tsof_n, tx_if.trn_teof_n, tx_if.trn_tsrc_rdy_n} !== 3'b111) begin
      errors++;
      $display("FAIL reset_strobes got %b want 111",
               {tx_if.trn_tsof_n, tx_if.trn_teof_n, tx_if.trn_tsrc_rdy_n});
    end
    @(posedge trn_clk); #1;
    reset_n = 1'b1; msien = 1'b1; tx_if.tx_grant = 1'b1; tx_if.trn_tdst_rdy_n = 1'b0;
  endtask

  task automatic test_single(input logic [63:0] a, input logic [15:0] d, input string nm);
    bit ok;
    addr = a; data = d;
    push_tlp(a, d);
    pulse_irq();
    @(negedge trn_clk);
    checks++;
    if (tx_if.tx_req !== 1'b1) begin
      errors++; $display("FAIL %s_req_latency got %b want 1", nm, tx_if.tx_req);
    end
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_done_timeout got none want tx_done", nm); end
    checks++;
    if (irq_count !== 32'(exp_count) || tx_if.tx_req !== 1'b0) begin
      errors++;
      $display("FAIL %s_count got count=%0d req=%b want %0d 0", nm, irq_count, tx_if.tx_req, exp_count);
    end
    idle_wait();
  endtask

  task automatic test_backpressure();
    bit ok;
    addr = 64'h0000_0000_ABCD_0123; data = 16'h00FF;
    push_tlp(addr, data);
    pulse_irq();
    wait_sof(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_sof_timeout got none want sof"); end
    @(posedge trn_clk); #1 tx_if.trn_tdst_rdy_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge trn_clk);
      checks++;
      if (tx_if.trn_td !== 64'hABCD_0120_FF00_0000 || tx_if.trn_tsrc_rdy_n !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall%0d got td=%h src=%b want td=abcd0120ff000000 src=0", i,
                 tx_if.trn_td, tx_if.trn_tsrc_rdy_n);
      end
    end
    @(posedge trn_clk); #1 tx_if.trn_tdst_rdy_n = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok || irq_count !== 32'(exp_count)) begin
      errors++; $display("FAIL bp_done got ok=%b count=%0d want 1 %0d", ok, irq_count, exp_count);
    end
    idle_wait();
  endtask

  task automatic test_coalesce();
    bit ok;
    bit seen;
    int t1;
    int t2;
    addr = 64'h0000_0000_FEE0_0000; data = 16'h0031;
    tx_if.tx_grant = 1'b0;
    push_tlp(addr, data);
    for (int i = 0; i < 3; i++) pulse_irq();
    @(negedge trn_clk);
    checks++;
    if (tx_if.tx_req !== 1'b1 || tx_if.trn_tsrc_rdy_n !== 1'b1) begin
      errors++;
      $display("FAIL coal_arb got req=%b src=%b want 1 1", tx_if.tx_req, tx_if.trn_tsrc_rdy_n);
    end
    @(posedge trn_clk); #1 tx_if.tx_grant = 1'b1;
    wait_sof(ok);
    irq = 1'b1;
    push_tlp(addr, data);
    @(negedge trn_clk); irq = 1'b0;
    wait_done(ok);
    t1 = cyc;
    checks++;
    if (!ok || tx_if.tx_req !== 1'b0) begin
      errors++; $display("FAIL coal_first got ok=%b req=%b want 1 0", ok, tx_if.tx_req);
    end
    seen = 1'b0;
    t2 = 0;
    for (int i = 0; i < int'(HOLD_LEN) + 50; i++) begin
      @(negedge trn_clk);
      if (tx_if.tx_req === 1'b1) begin seen = 1'b1; t2 = cyc; break; end
    end
    checks++;
    if (!seen || (t2 - t1) != int'(HOLD_LEN) + 1) begin
      errors++;
      $display("FAIL coal_spacing got seen=%b gap=%0d want gap=%0d", seen, t2 - t1, HOLD_LEN + 1);
    end
    wait_done(ok);
    checks++;
    if (!ok || irq_count !== 32'(exp_count)) begin
      errors++; $display("FAIL coal_second got ok=%b count=%0d want 1 %0d", ok, irq_count, exp_count);
    end
    idle_wait();
  endtask

  task automatic test_disabled();
    bit seen;
    msien = 1'b0;
    pulse_irq();
    seen = 1'b0;
    repeat (10) begin
      @(negedge trn_clk);
      if (tx_if.tx_req !== 1'b0) seen = 1'b1;
    end
    msien = 1'b1;
    repeat (5) begin
      @(negedge trn_clk);
      if (tx_if.tx_req !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen || irq_count !== 32'(exp_count)) begin
      errors++;
      $display("FAIL disabled_drop got req_seen=%b count=%0d want 0 %0d", seen, irq_count, exp_count);
    end
  endtask

  task automatic test_disable_mid();
    bit ok;
    bit seen;
    addr = 64'h0000_0000_0000_1000; data = 16'hA55A;
    push_tlp(addr, data);
    pulse_irq();
    wait_sof(ok);
    irq = 1'b1;
    @(negedge trn_clk); irq = 1'b0; msien = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok || irq_count !== 32'(exp_count)) begin
      errors++; $display("FAIL dismid_done got ok=%b count=%0d want 1 %0d", ok, irq_count, exp_count);
    end
    seen = 1'b0;
    repeat (HOLD_LEN + 10) begin
      @(negedge trn_clk);
      if (tx_if.tx_req !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL dismid_pending got req_seen=1 want 0"); end
    msien = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    addr = 64'h0000_0000_FEEF_F00C; data = 16'h4162;
    push_tlp(addr, data);
    pulse_irq();
    wait_sof(ok);
    @(posedge trn_clk); #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({tx_if.tx_req, tx_done, tx_if.trn_tsrc_rdy_n, tx_if.trn_tsof_n, tx_if.trn_teof_n} !== 5'b00111 ||
        {tx_if.trn_td, tx_if.trn_trem_n} !== 72'h0 || irq_count !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid got req=%b done=%b src=%b td=%h rem=%h count=%0d want 0 0 1 0 00 0",
               tx_if.tx_req, tx_done, tx_if.trn_tsrc_rdy_n, tx_if.trn_td, tx_if.trn_trem_n, irq_count);
    end
    exp_q.delete();
    exp_count = 0;
    repeat (2) @(posedge trn_clk);
    #1 reset_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge trn_clk);
      if (tx_if.tx_req !== 1'b0 || tx_if.trn_tsrc_rdy_n !== 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL reset_resume got activity=1 want 0"); end
  endtask

  initial begin
    tx_if.tx_grant       = 1'b0;
    tx_if.trn_tdst_rdy_n = 1'b1;
    test_reset();
    test_single(64'h0000_0000_FEEF_F00C, 16'h4162, "tlp3dw");
    test_single(64'h0000_0001_0000_0040, 16'hBEEF, "tlp4dw");
    test_backpressure();
    test_coalesce();
    test_disabled();
    test_disable_mid();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL leftover_beats got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msi_tlp_gen.md
MSI_TLP_GEN -- requirements
Module: msi_tlp_gen

Interface
REQ-001 Parameter HOLDOFF_CYCLES, default 256, minimum idle cycles between consecutive MSI TLPs; used only when MSI_HOLDOFF_EN is defined.
REQ-002 trn_clk  input  1  clock; every register is clocked on its rising edge.
REQ-003 reset_n  input  1  reset; asynchronous, active-low.
REQ-004 cfg_interrupt_msienable  input  1  MSI enabled by host.
REQ-005 msi_message_addr  input  64  MSI target address from the MSI vector reader.
REQ-006 msi_message_data  input  16  MSI data value from the MSI vector reader.
REQ-007 cfg_completer_id  input  16  bus/device/function, used as requester ID.
REQ-008 irq_req  input  1  single-cycle interrupt request strobe.
REQ-009 tx_req  output  1  request for ownership of the TRN TX channel.
REQ-010 tx_grant  input  1  TX arbiter grant, level.
REQ-011 trn_td  output  64  TX data; trn_trem_n output 8; trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n output 1 each; trn_tdst_rdy_n input 1.
REQ-012 tx_done  output  1  one-cycle pulse when an MSI TLP completes.
REQ-013 irq_count  output  32  count of MSI TLPs sent.

Function
REQ-014 irq_req while cfg_interrupt_msienable=1 shall set a pending flag; irq_req while cfg_interrupt_msienable=0 shall be dropped.
REQ-015 Multiple irq_req pulses arriving while pending is set shall coalesce into one TLP.
REQ-016 FSM states: IDLE, ARB, BEAT0, BEAT1, BEAT2, HOLD.
REQ-017 IDLE -> ARB when pending=1; tx_req=1 the cycle after irq_req is sampled in IDLE.
REQ-018 ARB: tx_req=1; when tx_grant=1, the block shall latch address and data, clear pending, and enter BEAT0.
REQ-019 Header DW0: fmt=3'b010 if msi_message_addr[63:32]==0, otherwise 3'b011; type=0, TC=0, TD=0, EP=0, attr=0, length=1.
REQ-020 Header DW1: {cfg_completer_id, tag 8'h00, lastBE 4'h0, firstBE 4'hF}.
REQ-021 Payload DW: {data[7:0], data[15:8], 16'h0000}.
REQ-022 3DW beats: BEAT0 = {DW0,DW1} with tsof_n=0. BEAT1 = {addr[31:2],2'b00, payload} with teof_n=0 and trem_n=8'h00.
REQ-023 4DW beats: BEAT0 = {DW0,DW1}. BEAT1 = {addr[63:32], addr[31:2],2'b00}. BEAT2 = {payload, 32'h0} with teof_n=0 and trem_n=8'h0F.
REQ-024 tsrc_rdy_n=0 in BEAT states only; a beat shall advance only on a cycle with trn_tdst_rdy_n=0, and trn_td shall hold stable otherwise.
REQ-025 On acceptance of the last beat: tx_done=1 for one cycle, irq_count increments (wraps at 2^32-1 -> 0), tx_req=0 from the next cycle, and the FSM enters HOLD.
REQ-026 HOLD -> IDLE after the holdoff interval (REQ-031/032).
REQ-027 irq_req arriving during ARB, BEAT or HOLD shall set pending and produce a further TLP afterwards; irq_req in the same cycle as the ARB grant shall remain pending.
REQ-028 cfg_interrupt_msienable falling mid-TLP shall not truncate that TLP; it shall clear pending in any state.

Reset
REQ-029 On reset_n=0: FSM=IDLE, pending=0, tx_req=0, tx_done=0, irq_count=0, trn_td=0, trn_trem_n=8'h00, and trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n=1.
REQ-030 Reset asserted mid-TLP shall abort immediately with the above values; no partial beat shall be resumed after reset.

Configuration
REQ-031 With MSI_HOLDOFF_EN defined: HOLD shall last exactly HOLDOFF_CYCLES cycles, counted by a down-counter loaded on entry to HOLD.
REQ-032 Without MSI_HOLDOFF_EN: HOLD shall last exactly one cycle, and no holdoff counter shall exist.

Verification
REQ-033 addr=64'h0000_0000_FEEF_F00C, data=16'h4162, grant immediate, tdst_rdy_n=0 -> two beats: 64'h4000_0001_xxxx_000F then 64'hFEEF_F00C_6241_0000, trem_n=00, tx_done, irq_count=1.
REQ-034 addr=64'h0000_0001_0000_0040 -> three beats, DW0=32'h6000_0001, last beat trem_n=8'h0F, payload in upper DW.
REQ-035 tdst_rdy_n=1 for 5 cycles during BEAT1 -> trn_td stable for those cycles, TLP completes intact.
REQ-036 Three irq_req pulses before grant -> one TLP; irq_req during BEAT0 -> second TLP, spaced 256 idle cycles with MSI_HOLDOFF_EN and 1 cycle without.
REQ-037 msienable=0 with irq_req -> no tx_req; reset_n low during BEAT1 -> all outputs at reset values in the same cycle, and no TLP is emitted after release without a new irq_req.
